// File: rtl/dac_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : dac_i2s_tx
// Description : I2S serial DAC transmitter fed from a non-showahead sample FIFO.
//               Define DAC_UNDERRUN_HOLD_EN to replay the last pair on underrun.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_i2s_tx #(
    parameter int BCK_DIV = 12
) (
    input  logic        clk_24mhz,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    output logic        dac_bck,
    output logic        dac_ws,
    output logic        dac_dat,
    output logic        frame_strobe,
    output logic        underrun,
    input  logic        underrun_clr
);
    localparam int               DIV_W    = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCH_L = 2'd1,
        WAIT_R  = 2'd2,
        LATCH_R = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      next_l;
    logic [15:0]      next_r;
    logic             hold_valid;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       slot;
    logic [4:0]       slot_nxt;
    logic [31:0]      shifter;
    logic [31:0]      fill_pair;
    logic             bck_fall;
    logic             frame_load;

    // Prefetch FSM: pops L then R; rdreq is gated by empty and held off in reset
    always_comb begin
        state_nxt  = state;
        fifo_rdreq = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && !hold_valid && !fifo_empty) begin
                    fifo_rdreq = 1'b1;
                    state_nxt  = LATCH_L;
                end
            end
            LATCH_L: state_nxt = WAIT_R;
            WAIT_R: begin
                if (!rst && !fifo_empty) begin
                    fifo_rdreq = 1'b1;
                    state_nxt  = LATCH_R;
                end
            end
            LATCH_R: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_24mhz) begin
        if (rst) begin
            state      <= IDLE;
            next_l     <= '0;
            next_r     <= '0;
            hold_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == LATCH_L) next_l <= fifo_q;
            if (state == LATCH_R) next_r <= fifo_q;
            if (state == LATCH_R) begin
                hold_valid <= 1'b1;
            end else if (frame_load && hold_valid) begin
                hold_valid <= 1'b0;
            end
        end
    end

    assign bck_fall   = en && dac_bck && (div_cnt == DIV_LAST);
    assign frame_load = bck_fall && (slot == 5'd31);
    assign slot_nxt   = slot + 5'd1;

`ifdef DAC_UNDERRUN_HOLD_EN
    logic [31:0] last_pair;

    always_ff @(posedge clk_24mhz) begin
        if (rst) begin
            last_pair <= '0;
        end else if (frame_load && hold_valid) begin
            last_pair <= {next_l, next_r};
        end
    end

    assign fill_pair = last_pair;
`else
    assign fill_pair = '0;
`endif

    // Slot 0 emits the old shifter MSB (previous right[0]) while the new pair loads
    always_ff @(posedge clk_24mhz) begin
        if (rst || !en) begin
            div_cnt      <= '0;
            dac_bck      <= 1'b0;
            slot         <= 5'd31;
            shifter      <= '0;
            dac_ws       <= 1'b0;
            dac_dat      <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= frame_load;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                dac_bck <= ~dac_bck;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (bck_fall) begin
                slot    <= slot_nxt;
                dac_ws  <= slot_nxt[4];
                dac_dat <= shifter[31];
                if (frame_load) begin
                    shifter <= hold_valid ? {next_l, next_r} : fill_pair;
                end else begin
                    shifter <= {shifter[30:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_24mhz) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (frame_load && !hold_valid) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_i2s_tx
// Description : Directed self-checking bench for dac_i2s_tx with a FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_i2s_tx;
    localparam int FRAME = 768;

`ifdef DAC_UNDERRUN_HOLD_EN
    localparam logic [15:0] FILL_L = 16'h8001;
    localparam logic [15:0] FILL_R = 16'h7FFE;
`else
    localparam logic [15:0] FILL_L = 16'h0000;
    localparam logic [15:0] FILL_R = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] fifo_q = '0;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic        dac_bck;
    logic        dac_ws;
    logic        dac_dat;
    logic        frame_strobe;
    logic        underrun;
    logic        underrun_clr = 1'b0;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [15:0] mem [0:63];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int rd_cnt  = 0;
    int rd_viol = 0;

    dac_i2s_tx #(.BCK_DIV(12)) dut (
        .clk_24mhz    (clk),
        .rst          (rst),
        .en           (en),
        .fifo_q       (fifo_q),
        .fifo_empty   (fifo_empty),
        .fifo_rdreq   (fifo_rdreq),
        .dac_bck      (dac_bck),
        .dac_ws       (dac_ws),
        .dac_dat      (dac_dat),
        .frame_strobe (frame_strobe),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    // Non-showahead FIFO: data appears the cycle after the pop
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rdreq) rd_cnt++;
        if (fifo_rdreq && fifo_empty) rd_viol++;
        if (fifo_rdreq && !fifo_empty) begin
            fifo_q <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        mem[wr_ptr % 64] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        while (frame_strobe !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    // Called on the strobe cycle; samples the middle of every slot of one frame
    task automatic capture_frame(output logic [15:0] l, output logic [15:0] r_hi,
                                 output logic b0, output int ws_bad,
                                 output int bck_bad, output int gap);
        l = '0; r_hi = '0; b0 = 1'b0; ws_bad = 0; bck_bad = 0; gap = -1;
        for (int i = 1; i <= FRAME; i++) begin
            step();
            if (frame_strobe === 1'b1 && gap < 0) gap = i;
            if (i < FRAME && dac_bck !== logic'(((i / 12) % 2) == 1)) bck_bad++;
            if (i % 24 == 12) begin
                int k;
                k = i / 24;
                if (dac_ws !== logic'(k >= 16)) ws_bad++;
                if (k == 0) b0 = dac_dat;
                else if (k <= 16) l[16-k] = dac_dat;
                else r_hi[32-k] = dac_dat;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        int rd0;
        int bad;
        rst = 1'b1; en = 1'b1; underrun_clr = 1'b0;
        repeat (3) step();
        rd0 = rd_cnt;
        rst = 1'b0;
        #1;
        chk_cnt++; if (dac_bck !== 1'b0) $display("FAIL rst_bck: got %b expected 0", dac_bck); else pass_cnt++;
        chk_cnt++; if (dac_ws !== 1'b0) $display("FAIL rst_ws: got %b expected 0", dac_ws); else pass_cnt++;
        chk_cnt++; if (dac_dat !== 1'b0) $display("FAIL rst_dat: got %b expected 0", dac_dat); else pass_cnt++;
        chk_cnt++; if (frame_strobe !== 1'b0) $display("FAIL rst_strobe: got %b expected 0", frame_strobe); else pass_cnt++;
        chk_cnt++; if (underrun !== 1'b0) $display("FAIL rst_underrun: got %b expected 0", underrun); else pass_cnt++;
        wait_strobe(100, n);
        chk_cnt++; if (n != 24) $display("FAIL empty_first_load: got %0d expected 24", n); else pass_cnt++;
        chk_cnt++; if (underrun !== 1'b1) $display("FAIL empty_underrun_set: got %b expected 1", underrun); else pass_cnt++;
        bad = 0;
        repeat (FRAME) begin
            step();
            if (dac_dat !== 1'b0) bad++;
        end
        chk_cnt++; if (bad != 0) $display("FAIL empty_dat_zero: got %0d nonzero samples expected 0", bad); else pass_cnt++;
        chk_cnt++; if (rd_cnt - rd0 != 0) $display("FAIL empty_no_rdreq: got %0d pops expected 0", rd_cnt - rd0); else pass_cnt++;
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk_cnt++; if (underrun !== 1'b0) $display("FAIL empty_underrun_clr: got %b expected 0", underrun); else pass_cnt++;
    endtask

    task automatic test_stream_and_drain();
        int n, first, second, rd0, ws_bad, bck_bad, gap, ws2, bck2, gap2;
        logic [15:0] la, ra, lb, rb;
        logic ba0, bb0;
        rst = 1'b1; en = 1'b1;
        repeat (2) step();
        push(16'h8001);
        push(16'h7FFE);
        step();
        rd0 = rd_cnt;
        rst = 1'b0;
        #1;
        first = -1; second = -1; n = 0;
        while (frame_strobe !== 1'b1 && n < 100) begin
            if (fifo_rdreq === 1'b1) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
            step();
            n++;
        end
        chk_cnt++; if (n != 24) $display("FAIL stream_first_load: got %0d expected 24", n); else pass_cnt++;
        chk_cnt++; if (first < 0 || second - first != 2) $display("FAIL stream_rdreq_spacing: got %0d/%0d expected 2 apart", first, second); else pass_cnt++;
        capture_frame(la, ra, ba0, ws_bad, bck_bad, gap);
        capture_frame(lb, rb, bb0, ws2, bck2, gap2);
        chk_cnt++; if (ba0 !== 1'b0) $display("FAIL stream_slot0_first: got %b expected 0", ba0); else pass_cnt++;
        chk_cnt++; if (la !== 16'h8001) $display("FAIL stream_left: got %h expected 8001", la); else pass_cnt++;
        chk_cnt++; if ({ra[15:1], bb0} !== 16'h7FFE) $display("FAIL stream_right: got %h expected 7ffe", {ra[15:1], bb0}); else pass_cnt++;
        chk_cnt++; if (ws_bad != 0) $display("FAIL stream_ws: got %0d bad slots expected 0", ws_bad); else pass_cnt++;
        chk_cnt++; if (bck_bad != 0) $display("FAIL stream_bck_period: got %0d bad samples expected 0", bck_bad); else pass_cnt++;
        chk_cnt++; if (gap != FRAME) $display("FAIL stream_strobe_gap: got %0d expected %0d", gap, FRAME); else pass_cnt++;
        chk_cnt++; if (rd_cnt - rd0 != 2) $display("FAIL stream_pop_count: got %0d expected 2", rd_cnt - rd0); else pass_cnt++;
        chk_cnt++; if (lb !== FILL_L) $display("FAIL drain_left: got %h expected %h", lb, FILL_L); else pass_cnt++;
        chk_cnt++; if (rb[15:1] !== FILL_R[15:1]) $display("FAIL drain_right: got %h expected %h", rb[15:1], FILL_R[15:1]); else pass_cnt++;
        chk_cnt++; if (underrun !== 1'b1) $display("FAIL drain_underrun: got %b expected 1", underrun); else pass_cnt++;
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk_cnt++; if (underrun !== 1'b0) $display("FAIL drain_underrun_clr: got %b expected 0", underrun); else pass_cnt++;
    endtask

    task automatic test_half_pair();
        int n, ws_bad, bck_bad, gap;
        logic [15:0] lc, rc, ld, rd;
        logic b0;
        rst = 1'b1; en = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #1;
        repeat (5) step();
        push(16'h1234);
        wait_strobe(100, n);
        n = n + 5;
        chk_cnt++; if (n != 24) $display("FAIL half_load_cycle: got %0d expected 24", n); else pass_cnt++;
        chk_cnt++; if (underrun !== 1'b1) $display("FAIL half_underrun: got %b expected 1", underrun); else pass_cnt++;
        push(16'h5678);
        capture_frame(lc, rc, b0, ws_bad, bck_bad, gap);
        chk_cnt++; if ({lc, rc[15:1]} !== 31'h0) $display("FAIL half_fill_frame: got %h/%h expected 0/0", lc, rc); else pass_cnt++;
        capture_frame(ld, rd, b0, ws_bad, bck_bad, gap);
        chk_cnt++; if (ld !== 16'h1234) $display("FAIL half_left: got %h expected 1234", ld); else pass_cnt++;
        chk_cnt++; if (rd[15:1] !== 15'h2B3C) $display("FAIL half_right: got %h expected 2b3c", rd[15:1]); else pass_cnt++;
    endtask

    task automatic test_rst_midframe();
        int n, ws_bad, bck_bad, gap;
        logic [15:0] l, r;
        logic b0;
        rst = 1'b1; en = 1'b1;
        repeat (2) step();
        push(16'h8001);
        push(16'h7FFE);
        rst = 1'b0;
        #1;
        wait_strobe(100, n);
        repeat (20 * 24 + 15) step();
        rst = 1'b1;
        step();
        chk_cnt++; if (dac_bck !== 1'b0) $display("FAIL midrst_bck: got %b expected 0", dac_bck); else pass_cnt++;
        chk_cnt++; if (dac_ws !== 1'b0) $display("FAIL midrst_ws: got %b expected 0", dac_ws); else pass_cnt++;
        chk_cnt++; if (dac_dat !== 1'b0) $display("FAIL midrst_dat: got %b expected 0", dac_dat); else pass_cnt++;
        chk_cnt++; if (fifo_rdreq !== 1'b0) $display("FAIL midrst_rdreq: got %b expected 0", fifo_rdreq); else pass_cnt++;
        push(16'h8001);
        push(16'h7FFE);
        step();
        rst = 1'b0;
        #1;
        wait_strobe(100, n);
        chk_cnt++; if (n != 24) $display("FAIL midrst_restart_load: got %0d expected 24", n); else pass_cnt++;
        capture_frame(l, r, b0, ws_bad, bck_bad, gap);
        chk_cnt++; if (l !== 16'h8001) $display("FAIL midrst_left: got %h expected 8001", l); else pass_cnt++;
        chk_cnt++; if (gap != FRAME) $display("FAIL midrst_gap: got %0d expected %0d", gap, FRAME); else pass_cnt++;
    endtask

    task automatic test_en_gap();
        int n, bad, ws_bad, bck_bad, gap;
        logic [15:0] l, r;
        logic b0;
        rst = 1'b1; en = 1'b1;
        repeat (2) step();
        push(16'h8001);
        push(16'h7FFE);
        rst = 1'b0;
        #1;
        wait_strobe(100, n);
        push(16'h1357);
        push(16'h2468);
        repeat (10 * 24 + 15) step();
        en = 1'b0;
        bad = 0;
        repeat (100) begin
            step();
            if ({dac_bck, dac_ws, dac_dat, frame_strobe} !== 4'b0000) bad++;
        end
        chk_cnt++; if (bad != 0) $display("FAIL engap_outputs_low: got %0d bad cycles expected 0", bad); else pass_cnt++;
        en = 1'b1;
        wait_strobe(2 * FRAME, n);
        chk_cnt++; if (frame_strobe !== 1'b1) $display("FAIL engap_reload: got no strobe within %0d cycles", n); else pass_cnt++;
        chk_cnt++; if (underrun !== 1'b0) $display("FAIL engap_underrun: got %b expected 0", underrun); else pass_cnt++;
        capture_frame(l, r, b0, ws_bad, bck_bad, gap);
        chk_cnt++; if (b0 !== 1'b0) $display("FAIL engap_slot0: got %b expected 0", b0); else pass_cnt++;
        chk_cnt++; if (l !== 16'h1357) $display("FAIL engap_left: got %h expected 1357", l); else pass_cnt++;
        chk_cnt++; if (r[15:1] !== 15'h1234) $display("FAIL engap_right: got %h expected 1234", r[15:1]); else pass_cnt++;
    endtask

    initial begin
        step();
        test_reset();
        test_stream_and_drain();
        test_half_pair();
        test_rst_midframe();
        test_en_gap();
        chk_cnt++; if (rd_viol != 0) $display("FAIL rdreq_while_empty: got %0d expected 0", rd_viol); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
